// File: rtl/serial_frame_deser_pkg.sv
// rtl/serial_frame_deser_pkg.sv - shared state encodings and line levels for the serial frame deserializer
// Purpose: FSM state type and the fixed line levels of the frame format.
// Ports: none (package).
package serial_frame_deser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    // Odd number of ones across data and parity bit means the even-parity check failed.
    function automatic logic parity_fail(input logic [15:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// rtl/serial_frame_deser_if.sv - serial input, sample enable and word handshake bundle
// Purpose: groups the serial line, enable and received-word handshake signals.
// Ports (signals): SIN, EN, DACK (toward deserializer); DOUT, DVALID, PERR, FERR, OVERRUN (from it).
// Modports: master = stimulus/consumer side, slave = deserializer side.
interface serial_frame_deser_if #(
    parameter int WIDTH = 8
);
    logic             SIN;
    logic             EN;
    logic             DACK;
    logic [WIDTH-1:0] DOUT;
    logic             DVALID;
    logic             PERR;
    logic             FERR;
    logic             OVERRUN;

    modport master (
        output SIN, EN, DACK,
        input  DOUT, DVALID, PERR, FERR, OVERRUN
    );

    modport slave (
        input  SIN, EN, DACK,
        output DOUT, DVALID, PERR, FERR, OVERRUN
    );
endinterface

// File: rtl/serial_frame_deser_bit_counter.sv
// rtl/serial_frame_deser_bit_counter.sv - modulo-WIDTH data bit counter with terminal count
// Purpose: counts received data bits; clear has priority over enable.
// Ports: clk_i, rst_ni (async active-low), clr_i, en_i, tc_o (count == WIDTH-1).
module serial_frame_deser_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/serial_frame_deser.sv
// rtl/serial_frame_deser.sv - deserializes start/data/parity/stop frames into words with a valid/ack handshake
// Purpose: frame FSM, shift register and output/handshake registers.
// Ports: CLK, RESET (async active-low), bus (slave modport: SIN, EN, DACK in;
//        DOUT, DVALID, PERR, FERR, OVERRUN out).
module serial_frame_deser
    import serial_frame_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    serial_frame_deser_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             pbit_q, pbit_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             frame_good;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    assign cnt_clr = bus.EN && (state_q == S_IDLE) && (bus.SIN == START_LVL);
    assign cnt_en  = bus.EN && (state_q == S_SHIFT);

    serial_frame_deser_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pbit_d     = pbit_q;
        dout_d     = dout_q;
        dvalid_d   = dvalid_q;
        perr_d     = perr_q;
        ferr_d     = 1'b0;
        overrun_d  = overrun_q;
        frame_good = 1'b0;

        if (bus.EN) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.SIN == START_LVL) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    // LSB arrives first, so bits enter at the top and walk down.
                    shreg_d = {bus.SIN, shreg_q[WIDTH-1:1]};
                    if (cnt_tc) state_d = S_PARITY;
                end
                S_PARITY: begin
                    pbit_d  = bus.SIN;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit is not reused as a start bit.
                    state_d = S_IDLE;
                    if (bus.SIN == STOP_LVL) frame_good = 1'b1;
                    else                     ferr_d     = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // An ack in the same cycle frees the output register for the new word;
        // that ack also consumes any pending overrun indication.
        if (frame_good && (!dvalid_q || bus.DACK)) begin
            dout_d    = shreg_q;
            perr_d    = parity_fail(16'(shreg_q), pbit_q);
            dvalid_d  = 1'b1;
            overrun_d = 1'b0;
        end else if (frame_good) begin
            overrun_d = 1'b1;
        end else if (bus.DACK && dvalid_q) begin
            dvalid_d  = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            pbit_q    <= 1'b0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pbit_q    <= pbit_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.DOUT    = dout_q;
    assign bus.DVALID  = dvalid_q;
    assign bus.PERR    = perr_q;
    assign bus.FERR    = ferr_q;
    assign bus.OVERRUN = overrun_q;
endmodule

// File: tb/tb_serial_frame_deser.sv
// tb/tb_serial_frame_deser.sv - self-checking bench for serial_frame_deser
module tb_serial_frame_deser;

    logic clk = 1'b0;
    logic rst_n;
    logic d = 1'b0;
    logic q_reg = 1'b0;
    logic force_q = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Edge-triggered DFF feeding the deserializer, with an override for the stuck-high case.
    always @(posedge clk) q_reg <= d;

    serial_frame_deser_if #(.WIDTH(8)) bus ();
    assign bus.SIN = force_q ? 1'b1 : q_reg;

    serial_frame_deser #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stopb;
        logic       dack_stop;
        logic       exp_pre_dv;
        logic [7:0] exp_dout;
        logic       exp_dv;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ov;
        logic       ack_after;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one full frame through the DFF; returns right after the stop-bit edge (+1).
    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopb,
                              input logic dack_stop, input logic en_tog, output logic pre_dv);
        logic [10:0] bits;
        bits = {stopb, pbit, data, 1'b1};
        pre_dv = 1'b0;
        if (!en_tog) begin
            for (int k = 0; k < 11; k++) begin
                @(negedge clk); d = bits[k];
            end
            @(negedge clk);
            pre_dv   = bus.DVALID;
            d        = 1'b0;
            bus.DACK = dack_stop;
        end else begin
            for (int k = 0; k < 11; k++) begin
                @(negedge clk); d = bits[k]; bus.EN = 1'b0;
                @(negedge clk); bus.EN = 1'b1;
                if (k == 10) begin
                    pre_dv   = bus.DVALID;
                    bus.DACK = dack_stop;
                end
            end
        end
        @(posedge clk); #1;
        bus.DACK = 1'b0;
        d        = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk); bus.DACK = 1'b1;
        @(posedge clk); #1; bus.DACK = 1'b0;
        chk("ack_dvalid", 16'(bus.DVALID), 16'h0);
        chk("ack_overrun", 16'(bus.OVERRUN), 16'h0);
    endtask

    initial begin
        logic pre_dv;

        //           data   p     stop  dack  pre   dout   dv    perr  ferr  ov    ack
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n    = 1'b0;
        bus.EN   = 1'b1;
        bus.DACK = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 16'(bus.DOUT), 16'h0);
        chk("rst_dvalid", 16'(bus.DVALID), 16'h0);
        chk("rst_perr", 16'(bus.PERR), 16'h0);
        chk("rst_ferr", 16'(bus.FERR), 16'h0);
        chk("rst_overrun", 16'(bus.OVERRUN), 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stopb, vecs[i].dack_stop, 1'b0, pre_dv);
            chk($sformatf("v%0d_pre_dvalid", i), 16'(pre_dv), 16'(vecs[i].exp_pre_dv));
            chk($sformatf("v%0d_dout", i), 16'(bus.DOUT), 16'(vecs[i].exp_dout));
            chk($sformatf("v%0d_dvalid", i), 16'(bus.DVALID), 16'(vecs[i].exp_dv));
            if (vecs[i].exp_dv)
                chk($sformatf("v%0d_perr", i), 16'(bus.PERR), 16'(vecs[i].exp_perr));
            chk($sformatf("v%0d_ferr", i), 16'(bus.FERR), 16'(vecs[i].exp_ferr));
            chk($sformatf("v%0d_overrun", i), 16'(bus.OVERRUN), 16'(vecs[i].exp_ov));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ferr_next", i), 16'(bus.FERR), 16'h0);
            chk($sformatf("v%0d_dvalid_next", i), 16'(bus.DVALID), 16'(vecs[i].exp_dv));
            if (vecs[i].ack_after) do_ack();
        end

        // Asynchronous reset in the middle of a frame while a word is still valid.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); d = 1'b1;
        end
        @(negedge clk); d = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_dvalid", 16'(bus.DVALID), 16'h0);
        chk("arst_dout", 16'(bus.DOUT), 16'h0);
        chk("arst_overrun", 16'(bus.OVERRUN), 16'h0);
        chk("arst_perr", 16'(bus.PERR), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, pre_dv);
        chk("post_rst_pre_dvalid", 16'(pre_dv), 16'h0);
        chk("post_rst_dout", 16'(bus.DOUT), 16'h5A);
        chk("post_rst_dvalid", 16'(bus.DVALID), 16'h1);
        chk("post_rst_perr", 16'(bus.PERR), 16'h0);
        do_ack();

        // Sample enable toggling every cycle.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, pre_dv);
        bus.EN = 1'b1;
        chk("en_tog_pre_dvalid", 16'(pre_dv), 16'h0);
        chk("en_tog_dout", 16'(bus.DOUT), 16'hA5);
        chk("en_tog_dvalid", 16'(bus.DVALID), 16'h1);
        chk("en_tog_perr", 16'(bus.PERR), 16'h0);
        do_ack();

        // Line forced high for 50 time units while idle; D stays high long enough
        // that every bit of the frame, including the stop bit, reads as one.
        @(negedge clk); force_q = 1'b1; d = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 5)  force_q = 1'b0;
            if (j == 10) d = 1'b0;
        end
        @(posedge clk); #1;
        chk("force_ferr", 16'(bus.FERR), 16'h1);
        chk("force_dvalid", 16'(bus.DVALID), 16'h0);
        @(posedge clk); #1;
        chk("force_ferr_next", 16'(bus.FERR), 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("force_idle_dvalid", 16'(bus.DVALID), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
